// File: rtl/sync_debounce.sv
// Multi-channel synchronizer plus per-channel glitch filter with optional edge pulses.
// Define SYNC_DEBOUNCE_EDGE_EN to generate the rise/fall pulse outputs.
module sync_debounce #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  generate
    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
      $fatal(1, "sync_debounce: DEPTH must be within 2..8");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 65535) begin : g_bad_filter
      $fatal(1, "sync_debounce: FILTER_CYCLES must be within 1..65535");
    end
  endgenerate

  logic [WIDTH-1:0] chain [DEPTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] accept;
  logic [CW-1:0]    cnt [WIDTH];

  assign s = chain[DEPTH-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) chain[k] <= '0;
    end else begin
      chain[0] <= in;
      for (int unsigned k = 1; k < DEPTH; k++) chain[k] <= chain[k-1];
    end
  end

  // A channel accepts on the edge that completes FILTER_CYCLES consecutive disagreeing samples.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      accept[i] = (s[i] != out[i]) && (cnt[i] == CW'(FILTER_CYCLES - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s[i] == out[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          out[i] <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef SYNC_DEBOUNCE_EDGE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= accept & s;
      fall <= accept & ~s;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL provide parameter WIDTH, default 1: number of independent single-bit channels.
REQ-002 SHALL provide parameter DEPTH, default 2: synchronizer flop stages per channel, legal range 2..8.
REQ-003 SHALL provide parameter FILTER_CYCLES, default 4: consecutive cycles a synchronized value must hold before output accepts it, legal range 1..65535.
REQ-004 SHALL provide port clock, input, 1 bit: sole clock; every flop samples on its rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide port in, input, WIDTH bits: asynchronous or foreign-domain channel inputs.
REQ-007 SHALL provide port out, output, WIDTH bits: synchronized, debounced channel levels, registered.
REQ-008 SHALL provide port rise, output, WIDTH bits: one-cycle pulse per channel on out 0->1, registered.
REQ-009 SHALL provide port fall, output, WIDTH bits: one-cycle pulse per channel on out 1->0, registered.

Function
REQ-010 SHALL pass each in bit through a DEPTH-stage flop chain; chain output is termed s[i].
REQ-011 SHALL keep one counter per channel, width ceil(log2(FILTER_CYCLES+1)), never wrapping.
REQ-012 Per channel per cycle SHALL apply: s==out -> counter<=0; s!=out and counter==FILTER_CYCLES-1 -> out<=s, counter<=0; else counter<=counter+1.
REQ-013 SHALL give total latency from an in change (stable thereafter) to out change of exactly DEPTH+FILTER_CYCLES rising edges.
REQ-014 SHALL discard any s pulse shorter than FILTER_CYCLES cycles: out unchanged, no rise/fall pulse, counter back to 0.
REQ-015 With FILTER_CYCLES=1 SHALL update out one edge after s differs (no filtering).
REQ-016 SHALL assert rise[i] (fall[i]) for exactly the first cycle out[i] holds its new value 1 (0); never both on one channel simultaneously.
REQ-017 SHALL process channels independently; simultaneous updates on several channels in one cycle SHALL all take effect that cycle.
REQ-018 SHALL NOT stall or hold state other than the chain, counters, out, rise, fall.
REQ-019 SHALL flag illegal DEPTH or FILTER_CYCLES at elaboration (fatal).

Reset
REQ-020 While reset is high at a rising edge, every chain stage, counter, out, rise and fall SHALL load 0.
REQ-021 Reset SHALL take priority over all function; reset mid-filter SHALL abandon the count, so post-release acceptance again needs the full DEPTH+FILTER_CYCLES edges.
REQ-022 First cycle after reset release SHALL show out=0, rise=0, fall=0 regardless of in.

Configuration
REQ-023 Macro SYNC_DEBOUNCE_EDGE_EN defined: rise and fall SHALL behave per REQ-016.
REQ-024 Macro SYNC_DEBOUNCE_EDGE_EN undefined: rise and fall SHALL be constant 0 with no edge flops instantiated; out behaviour SHALL be identical.

Verification (WIDTH=4, DEPTH=2, FILTER_CYCLES=3, macro defined unless noted)
REQ-025 Reset 3 cycles with in=4'hF -> out=0, rise=fall=0 during reset and first cycle after.
REQ-026 After reset, in[0] 0->1 held -> out[0]=1 exactly 5 edges after change; rise[0] high for that one cycle only.
REQ-027 in[1] high 2 cycles then low -> out[1] stays 0, rise/fall[1] never assert.
REQ-028 out[3]=1 established; same cycle in[2] 0->1 and in[3] 1->0 -> out=4'b0101 (bit2 set, bit3 clear) same edge, rise[2] and fall[3] both pulse one cycle.
REQ-029 in[0] 0->1, reset asserted one cycle when counter[0]=2, then released with in[0] still 1 -> out[0]=1 exactly 5 edges after release.
REQ-030 Macro undefined, repeat REQ-026 and REQ-028 -> identical out timing, rise=fall=0 throughout.
